// File: rtl/dmem_dump_pkg.sv
// ----------------------------------------------------------------------------
// dmem_dump_pkg
// Shared definitions for the data-memory dump unit: default geometry,
// the sequencer state enumeration and an address-width helper.
// No ports (package).
// ----------------------------------------------------------------------------
package dmem_dump_pkg;

    localparam int DMEM_DATA_W_DEFAULT = 16;
    localparam int DMEM_DEPTH_DEFAULT  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } dump_state_e;

    // Keep at least one address bit so a single-word memory still elaborates.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_dump_order_checker.sv
// ----------------------------------------------------------------------------
// order_checker
// Watches the stream of words read by the dump unit and reports whether they
// are non-decreasing (unsigned). Only the first out-of-order address is kept.
// Built only when DMEM_DUMP_CHECK_EN is defined (instantiated by the top).
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   clear_i      start of a new dump: sorted -> 1, viol_addr -> 0
//   valid_i      a word is being captured this cycle
//   addr_i       address of the captured word
//   data_i       captured word
//   sorted_o     1 while no out-of-order word has been seen
//   viol_addr_o  address of the first word smaller than its predecessor
// ----------------------------------------------------------------------------
module order_checker #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              sorted_o,
    output logic [ADDR_W-1:0] viol_addr_o
);

    logic              have_prev_q;
    logic [DATA_W-1:0] prev_q;
    logic              sorted_q;
    logic [ADDR_W-1:0] viol_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            sorted_q    <= 1'b0;
            viol_q      <= '0;
        end else if (clear_i) begin
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            sorted_q    <= 1'b1;
            viol_q      <= '0;
        end else if (valid_i) begin
            prev_q      <= data_i;
            have_prev_q <= 1'b1;
            // sorted_q still set means no violation yet, so this is the first.
            if (have_prev_q && sorted_q && (data_i < prev_q)) begin
                sorted_q <= 1'b0;
                viol_q   <= addr_i;
            end
        end
    end

    assign sorted_o    = sorted_q;
    assign viol_addr_o = viol_q;

endmodule

// File: rtl/dmem_dump_unit.sv
// ----------------------------------------------------------------------------
// dmem_dump_unit
// Reads DEPTH words from the CPU data memory (one-cycle read latency) and
// streams them out with a valid/ready handshake, one word at a time
// (READ -> WAIT -> EMIT per word). Optionally checks the words are sorted.
//
// Build option: define DMEM_DUMP_CHECK_EN to build the order checker;
// without it sorted/viol_addr are tied to 0.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               one-cycle dump request (ignored while busy)
//   mem_rd_en/addr      read strobe and address to the data memory
//   mem_rd_data         read data, valid the cycle after mem_rd_en
//   out_valid/ready     stream handshake
//   out_addr/out_data   address and value of the streamed word
//   busy                dump in progress
//   done                one-cycle completion pulse
//   sorted, viol_addr   order-check result (held until next start)
// ----------------------------------------------------------------------------
module dmem_dump_unit
    import dmem_dump_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W_DEFAULT,
    parameter int DEPTH  = DMEM_DEPTH_DEFAULT,
    localparam int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              sorted,
    output logic [ADDR_W-1:0] viol_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                out_addr_q <= cnt_q;
                out_data_q <= mem_rd_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        out_valid   = 1'b0;
        done        = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = cnt_q;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                capture = 1'b1;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;

`ifdef DMEM_DUMP_CHECK_EN
    order_checker #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_order_checker (
        .clk_i       (clock),
        .rst_i       (reset),
        .clear_i     ((state_q == ST_IDLE) && start),
        .valid_i     (capture),
        .addr_i      (cnt_q),
        .data_i      (mem_rd_data),
        .sorted_o    (sorted),
        .viol_addr_o (viol_addr)
    );
`else
    assign sorted    = 1'b0;
    assign viol_addr = '0;
`endif

endmodule

// File: tb/tb_dmem_dump_unit.sv
module tb_dmem_dump_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        mem_rd_en;
    logic [3:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_addr;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic        sorted;
    logic [3:0]  viol_addr;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [16];

    dmem_dump_unit #(
        .DATA_W (16),
        .DEPTH  (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .sorted      (sorted),
        .viol_addr   (viol_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory with one-cycle read latency.
    initial mem_rd_data = '0;
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: first index whose word is below its predecessor (unsigned).
    task automatic ref_order(output bit s, output logic [3:0] v);
        s = 1'b1;
        v = '0;
        for (int i = 1; i < 16; i++) begin
            if (s && (mem[i] < mem[i-1])) begin
                s = 1'b0;
                v = 4'(i);
            end
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 16; i++) begin
            case (pat)
                0: mem[i] = 16'(3 * i + 1);
                1: mem[i] = 16'(i);
                2: mem[i] = 16'h0005;
                default: mem[i] = 16'hFFFF;
            endcase
        end
        if (pat == 1) begin
            mem[4] = 16'd9;
            mem[5] = 16'd2;
            mem[9] = 16'd0;
        end
        if (pat == 3) begin
            mem[0] = 16'h7FFF;
            mem[1] = 16'h8000;
        end
    endtask

    // rmode: 0 ready always, 1 random ready, 2 ready dropped 10 cycles at beat 3.
    task automatic run_dump(input int rmode, input int restart_beat, input int reset_beat,
                            input bit exp_s_in, input logic [3:0] exp_v_in);
        int t, beats, drop_left;
        bit dropped, restarted, seen_done, prev_stall, first_seen, exp_s;
        logic [15:0] pd;
        logic [3:0]  pa, exp_v;
        exp_s = exp_s_in;
        exp_v = exp_v_in;
`ifndef DMEM_DUMP_CHECK_EN
        exp_s = 1'b0;
        exp_v = '0;
`endif
        beats = 0; drop_left = 0; dropped = 0; restarted = 0;
        seen_done = 0; prev_stall = 0; first_seen = 0; pd = '0; pa = '0;
        @(negedge clock);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        t = 1;
        while (!seen_done && t < 2000) begin
            if (reset_beat >= 0 && beats == reset_beat) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("reset_mid_data", 32'(out_data), 32'd0);
                chk("reset_mid_ctl", 32'({mem_rd_en, mem_rd_addr, out_valid, out_addr,
                                          busy, done, sorted, viol_addr}), 32'd0);
                return;
            end
            start = (restart_beat >= 0 && beats == restart_beat && !restarted);
            if (start) restarted = 1;
            case (rmode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!dropped && beats == 3 && out_valid) begin
                        dropped = 1;
                        drop_left = 10;
                    end
                    if (drop_left > 0) begin
                        out_ready = 1'b0;
                        drop_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase

            chk("busy", 32'(busy), 32'd1);
            if (mem_rd_en) chk("rd_addr", 32'(mem_rd_addr), 32'(beats));
            if (out_valid) chk("rd_in_emit", 32'(mem_rd_en), 32'd0);
            if (out_valid && !first_seen) begin
                first_seen = 1;
                chk("first_valid_cycle", 32'(t), 32'd3);
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(pd));
                chk("stall_addr", 32'(out_addr), 32'(pa));
            end
            if (out_valid && out_ready) begin
                chk("beat_addr", 32'(out_addr), 32'(beats));
                if (beats < 16) chk("beat_data", 32'(out_data), 32'(mem[beats]));
                beats++;
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pa = out_addr;
            if (done) begin
                seen_done = 1;
                chk("beat_count", 32'(beats), 32'd16);
                if (rmode == 0) chk("done_latency", 32'(t), 32'd49);
                chk("sorted", 32'(sorted), 32'(exp_s));
                chk("viol_addr", 32'(viol_addr), 32'(exp_v));
            end
            @(negedge clock);
            t++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", t);
        end else begin
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_after_done", 32'(busy), 32'd0);
            repeat (3) @(negedge clock);
            chk("sorted_hold", 32'(sorted), 32'(exp_s));
            chk("viol_hold", 32'(viol_addr), 32'(exp_v));
        end
    endtask

    typedef struct {
        int         pat;
        int         rmode;
        int         restart_beat;
        int         reset_beat;
        bit         exp_s;
        logic [3:0] exp_v;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit         rs;
        logic [3:0] rv;
        int         acc;

        vecs[0] = '{0, 0, -1, -1, 1'b1, 4'd0};  // ascending 3i+1
        vecs[1] = '{1, 0, -1, -1, 1'b0, 4'd5};  // multiple violations
        vecs[2] = '{0, 2, -1, -1, 1'b1, 4'd0};  // back-pressure at beat 3
        vecs[3] = '{2, 0, -1, -1, 1'b1, 4'd0};  // all equal
        vecs[4] = '{0, 0,  6, -1, 1'b1, 4'd0};  // start at beat 6 ignored
        vecs[5] = '{3, 0, -1, -1, 1'b1, 4'd0};  // unsigned compare
        vecs[6] = '{0, 0, -1,  7, 1'b1, 4'd0};  // reset at beat 7
        vecs[7] = '{0, 0, -1, -1, 1'b1, 4'd0};  // resume from addr 0

        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) @(negedge clock);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_ctl", 32'({mem_rd_en, mem_rd_addr, out_valid, out_addr,
                              busy, done, sorted, viol_addr}), 32'd0);

        // Reset and start on the same edge: reset wins.
        start = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_over_start_busy", 32'(busy), 32'd0);
        @(negedge clock);
        chk("rst_over_start_rd", 32'({busy, mem_rd_en}), 32'd0);

        for (int v = 0; v < 8; v++) begin
            fill(vecs[v].pat);
            run_dump(vecs[v].rmode, vecs[v].restart_beat, vecs[v].reset_beat,
                     vecs[v].exp_s, vecs[v].exp_v);
        end

        for (int k = 0; k < 6; k++) begin
            acc = 0;
            for (int i = 0; i < 16; i++) begin
                if (k % 2 == 1) begin
                    acc = acc + int'($urandom_range(0, 3));
                    mem[i] = 16'(acc);
                end else begin
                    mem[i] = 16'($urandom_range(0, 20));
                end
            end
            ref_order(rs, rv);
            run_dump(1, -1, -1, rs, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_dump_unit.md
DMEM_DUMP_UNIT -- requirements
Module: dmem_dump_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data memory word width.
REQ-002 SHALL have parameter DEPTH, default 16: number of data memory words scanned; ADDR_W = clog2(DEPTH), which is 4 at the default.
REQ-003 SHALL use one clock and a synchronous, active-high reset. Ports `clock` and `reset` SHALL be the only clock and reset.
REQ-004 SHALL have ports `clock` (in, 1) as the rising-edge clock, and `reset` (in, 1) as the synchronous active-high reset.
REQ-005 SHALL have ports:
- `start` (in, 1): one-cycle request to begin a dump.
- `mem_rd_en` (out, 1): read strobe to the CPU data memory read port.
- `mem_rd_addr` (out, ADDR_W): read address.
- `mem_rd_data` (in, DATA_W): read data, valid the cycle after `mem_rd_en`.
REQ-006 SHALL have ports:
- `out_valid` (out, 1): stream word valid.
- `out_ready` (in, 1): consumer ready.
- `out_addr` (out, ADDR_W): address of the streamed word.
- `out_data` (out, DATA_W): streamed word.
REQ-007 SHALL have ports:
- `busy` (out, 1): a dump is in progress.
- `done` (out, 1): one-cycle completion pulse.
- `sorted` (out, 1): all words are non-decreasing.
- `viol_addr` (out, ADDR_W): first out-of-order address.

Function
REQ-008 SHALL implement FSM states IDLE, READ, WAIT, EMIT and DONE.
REQ-009 IDLE SHALL go to READ on `start`=1, with the address counter set to 0; `busy` SHALL be 1 in every state except IDLE.
REQ-010 READ SHALL drive `mem_rd_en`=1 and `mem_rd_addr`=counter for exactly one cycle, then go to WAIT.
REQ-011 WAIT SHALL capture `mem_rd_data` into the output register at the end of the cycle, then go to EMIT.
REQ-012 EMIT SHALL hold `out_valid`=1. `out_data` and `out_addr` SHALL stay stable until a cycle in which `out_valid`=1 and `out_ready`=1.
REQ-013 On an EMIT handshake, the FSM SHALL go to DONE if the counter equals DEPTH-1; otherwise it SHALL increment the counter and go to READ.
REQ-014 DONE SHALL assert `done`=1 for exactly one cycle, then go to IDLE.
REQ-015 Minimum cost SHALL be 3 cycles per word with `out_ready` held at 1. From a `start` sampled on edge k, the first `out_valid` SHALL appear in cycle k+3, and `done` SHALL appear 3*DEPTH+1 cycles after k (49 at defaults).
REQ-016 `start` SHALL be ignored outside IDLE. No read SHALL be issued while in EMIT.
REQ-017 Order check: each word SHALL be compared, unsigned, with the previous word.
- Equal words SHALL count as in order.
- The first word for which current < previous SHALL clear `sorted` and latch that word's address into `viol_addr`.
- Later violations SHALL NOT overwrite `viol_addr`.
REQ-018 On `start`, `sorted` SHALL be set to 1 and `viol_addr` to 0. Both SHALL be held from DONE until the next `start`.
REQ-019 The counter SHALL NOT wrap within a dump; the dump SHALL terminate at DEPTH-1.

Reset
REQ-020 On `reset`=1 the FSM SHALL return to IDLE and the counter SHALL go to 0.
REQ-021 All outputs SHALL be 0 from the cycle after `reset` is sampled: `mem_rd_en`, `mem_rd_addr`, `out_valid`, `out_addr`, `out_data`, `busy`, `done`, `sorted` and `viol_addr`.
REQ-022 `reset` SHALL override `start` when both are sampled on the same edge. A read in flight SHALL be discarded.

Configuration
REQ-023 With macro DMEM_DUMP_CHECK_EN defined, the order check of REQ-017 and REQ-018 SHALL be built.
REQ-024 Without DMEM_DUMP_CHECK_EN, `sorted` and `viol_addr` SHALL be tied to 0, no comparator logic SHALL exist, and streaming SHALL be unchanged.

Structure
REQ-025 Package dmem_dump_pkg SHALL hold the FSM state enumeration and the default DATA_W and DEPTH constants.
REQ-026 The order check SHALL be sub-module order_checker (previous-word register, comparator, first-violation latch). It SHALL be instantiated only under DMEM_DUMP_CHECK_EN.

Verification
REQ-027 Ascending case: preload mem[i]=3*i+1, pulse `start`, hold `out_ready`=1. Required: 16 beats at addr 0..15 with matching data; `done` pulse 49 cycles after `start`; `sorted`=1; `viol_addr`=0.
REQ-028 Multiple violations: ascending data except mem[4]=9, mem[5]=2, mem[9]=0. Required: `sorted`=0 and `viol_addr`=5 at `done`.
REQ-029 Back-pressure and equal values:
- Drop `out_ready` for 10 cycles at beat 3. Required: `out_valid` held, `out_data`/`out_addr` unchanged, `mem_rd_en`=0 throughout.
- Preload all words 0x0005. Required: `sorted`=1.
REQ-030 Restart rules:
- Pulse `start` again at beat 6. Required: it is ignored, and exactly 16 beats are produced.
- Assert `reset` at beat 7. Required: all outputs 0 the next cycle; a new `start` resumes from addr 0.
REQ-031 Unsigned compare and macro-off: mem[0]=0x7FFF, mem[1]=0x8000, remaining words 0xFFFF. Required: `sorted`=1. With the macro undefined, required: `sorted`=0 and `viol_addr`=0 always.
